// File: rtl/timer_defs.sv
// Shared encodings for the timing counter bank: channel run state and count mode.
package timer_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/NBitAddSub.sv
// N-bit adder/subtractor: s = a + b when sub=0, s = a - b (two's complement) when sub=1.
module NBitAddSub #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s
);

  assign s = a + (b ^ {N{sub}}) + N'(sub);

endmodule

// File: rtl/down_timer_chan.sv
// One down-counting timer channel: load, decrement while enabled, one-cycle tc at terminal
// count, then either stop at zero (one-shot) or restart from the reload value.
import timer_defs::*;

module down_timer_chan #(
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic                  en,
  input  logic                  mode,
  input  logic [COUNT_BITS-1:0] load_val,
  output logic [COUNT_BITS-1:0] count,
  output logic                  zero,
  output logic                  tc,
  output logic                  busy
);

  chan_state_t           state;
  logic [COUNT_BITS-1:0] reload;
  logic [COUNT_BITS-1:0] count_dec;

  NBitAddSub #(.N(COUNT_BITS)) u_dec (
    .a   (count),
    .b   (COUNT_BITS'(1)),
    .sub (1'b1),
    .s   (count_dec)
  );

  // While in RUN the count is never 0, so terminal count is detected at 1 and no wrap occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else if (ld) begin
      count  <= load_val;
      reload <= load_val;
      state  <= (load_val != '0) ? ST_RUN : ST_IDLE;
      tc     <= 1'b0;
    end else if (state == ST_RUN && en) begin
      if (count == COUNT_BITS'(1)) begin
        tc <= 1'b1;
        if (mode == MODE_RELOAD) begin
          count <= reload;
        end else begin
          count <= '0;
          state <= ST_IDLE;
        end
      end else begin
        count <= count_dec;
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign zero = (count == '0);
  assign busy = (state == ST_RUN);

endmodule

// File: rtl/timing_counter_bank.sv
// Bank of NUM_CH independent down-timer channels with packed count buses and a combined busy flag.
import timer_defs::*;

module timing_counter_bank #(
  parameter int COUNT_BITS = 8,
  parameter int NUM_CH     = 4,
  parameter int PATH_DELAY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ld,
  input  logic [NUM_CH-1:0]            en,
  input  logic [NUM_CH-1:0]            mode,
  input  logic [NUM_CH*COUNT_BITS-1:0] load_val,
  output logic [NUM_CH*COUNT_BITS-1:0] count,
  output logic [NUM_CH-1:0]            zero,
  output logic [NUM_CH-1:0]            tc,
  output logic                         busy
);

  logic [NUM_CH-1:0] busy_ch;

  if (NUM_CH < 1 || NUM_CH > 16 || COUNT_BITS < 1 || PATH_DELAY < 0) begin : g_bad_param
    $error("timing_counter_bank: unsupported parameter value");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    down_timer_chan #(.COUNT_BITS(COUNT_BITS)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld[i]),
      .en       (en[i]),
      .mode     (mode[i]),
      .load_val (load_val[i*COUNT_BITS +: COUNT_BITS]),
      .count    (count[i*COUNT_BITS +: COUNT_BITS]),
      .zero     (zero[i]),
      .tc       (tc[i]),
      .busy     (busy_ch[i])
    );
  end

  assign busy = |busy_ch;

endmodule

// File: tb/tb_timing_counter_bank.sv
// Bench for timing_counter_bank: directed scenarios plus random traffic against a behavioural model.
module tb_timing_counter_bank;

  localparam int CB = 8;
  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    ld, en, mode;
  logic [NC*CB-1:0] load_val;
  logic [NC*CB-1:0] count;
  logic [NC-1:0]    zero, tc;
  logic             busy;

  timing_counter_bank #(.COUNT_BITS(CB), .NUM_CH(NC), .PATH_DELAY(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .en       (en),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: one integer count, reload value and running flag per channel.
  int unsigned m_cnt[NC];
  int unsigned m_rld[NC];
  bit          m_run[NC];
  bit          m_tc[NC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_edge();
    for (int c = 0; c < NC; c++) begin
      int unsigned lv;
      lv = int'(load_val[c*CB +: CB]);
      m_tc[c] = 1'b0;
      if (rst) begin
        m_cnt[c] = 0;
        m_rld[c] = 0;
        m_run[c] = 1'b0;
      end else if (ld[c]) begin
        m_cnt[c] = lv;
        m_rld[c] = lv;
        m_run[c] = (lv != 0);
      end else if (m_run[c] && en[c]) begin
        if (m_cnt[c] == 1) begin
          m_tc[c] = 1'b1;
          if (mode[c]) m_cnt[c] = m_rld[c];
          else begin
            m_cnt[c] = 0;
            m_run[c] = 1'b0;
          end
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endfunction

  task automatic step();
    logic [NC-1:0] exp_zero;
    logic          exp_busy;
    @(posedge clk);
    model_edge();
    #1;
    exp_busy = 1'b0;
    for (int c = 0; c < NC; c++) begin
      exp_zero[c] = (m_cnt[c] == 0);
      exp_busy    = exp_busy | m_run[c];
      check_eq($sformatf("count%0d", c), 32'(count[c*CB +: CB]), m_cnt[c]);
      check_eq($sformatf("tc%0d", c), 32'(tc[c]), 32'(m_tc[c]));
    end
    check_eq("zero", 32'(zero), 32'(exp_zero));
    check_eq("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic set_ch(input int c, input bit l, input bit e, input bit m, input int v);
    ld[c]               = l;
    en[c]               = e;
    mode[c]             = m;
    load_val[c*CB +: CB] = CB'(v);
  endtask

  task automatic clear_inputs();
    ld = '0; en = '0; mode = '0; load_val = '0;
  endtask

  initial begin
    int seq036[4];
    seq036 = '{3, 2, 1, 0};
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    check_eq("reset_zero_all", 32'(zero), 32'hF);
    check_eq("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // One-shot from 3: 3,2,1,0 with tc on reaching 0.
    set_ch(0, 1, 1, 0, 3);
    for (int k = 0; k < 4; k++) begin
      step();
      ld[0] = 1'b0;
      check_eq("oneshot_seq", 32'(count[0 +: CB]), 32'(seq036[k]));
      check_eq("oneshot_tc", 32'(tc[0]), (k == 3) ? 32'h1 : 32'h0);
    end
    step();
    check_eq("oneshot_idle_busy", 32'(busy), 32'h0);

    // Auto-reload from 2: 2,1,2,1,...
    set_ch(0, 1, 1, 1, 2);
    step();
    ld[0] = 1'b0;
    repeat (6) step();

    // Enable gating from count 5.
    set_ch(0, 1, 1, 0, 5);
    step();
    ld[0] = 1'b0;
    step();
    en[0] = 1'b0; step();
    step();
    en[0] = 1'b1; step();
    check_eq("en_gate_count", 32'(count[0 +: CB]), 32'd3);

    // Load wins over terminal count.
    set_ch(0, 1, 1, 0, 2);
    step();
    ld[0] = 1'b0;
    step();
    set_ch(0, 1, 1, 0, 7);
    step();
    check_eq("ld_over_tc_count", 32'(count[0 +: CB]), 32'd7);
    check_eq("ld_over_tc_tc", 32'(tc[0]), 32'h0);
    ld[0] = 1'b0;

    // Reset mid-count aborts with no tc; IDLE ignores en.
    set_ch(0, 1, 1, 0, 6);
    step();
    ld[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_abort_zero", 32'(zero[0]), 32'h1);
    repeat (2) step();

    // Four channels loaded 1,2,3,0 together.
    clear_inputs();
    for (int c = 0; c < NC; c++) set_ch(c, 1, 1, 0, (c == 3) ? 0 : c + 1);
    step();
    ld = '0;
    repeat (5) step();
    check_eq("multi_busy_end", 32'(busy), 32'h0);

    // Reload value 1 gives tc every enabled cycle.
    clear_inputs();
    set_ch(2, 1, 1, 1, 1);
    step();
    ld[2] = 1'b0;
    repeat (4) step();
    clear_inputs();

    // Full-range count from the maximum value.
    set_ch(1, 1, 1, 0, (1 << CB) - 1);
    step();
    ld[1] = 1'b0;
    repeat ((1 << CB) + 2) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int c = 0; c < NC; c++) begin
        set_ch(c, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? (1 << CB) - 1 : $urandom_range(0, 5));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_counter_bank.md
TIMING_COUNTER_BANK -- requirements
Module: timing_counter_bank

Interface
REQ-001 SHALL have parameter COUNT_BITS, default 8: width of each channel counter.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent channels (1..16).
REQ-003 SHALL have parameter PATH_DELAY, default 3: simulation-only delay on registered outputs, no functional effect.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ld  input  NUM_CH  per-channel load strobe.
REQ-007 SHALL have port en  input  NUM_CH  per-channel count enable.
REQ-008 SHALL have port mode  input  NUM_CH  per-channel mode: 0 one-shot, 1 auto-reload.
REQ-009 SHALL have port load_val  input  NUM_CH*COUNT_BITS  per-channel start value; channel i uses bits [i*COUNT_BITS +: COUNT_BITS].
REQ-010 SHALL have port count  output  NUM_CH*COUNT_BITS  per-channel current count, registered, same packing as load_val.
REQ-011 SHALL have port zero  output  NUM_CH  per-channel flag: count == 0, decoded from the count register.
REQ-012 SHALL have port tc  output  NUM_CH  per-channel terminal-count pulse, registered, one cycle wide.
REQ-013 SHALL have port busy  output  1  OR over all channels of (state == RUN).

Function
REQ-014 Each channel SHALL be independent; no channel's inputs affect another channel's outputs.
REQ-015 Each channel SHALL hold a state of IDLE or RUN, a count register, and a reload register.
REQ-016 ld=1 SHALL load count and reload with load_val on the next edge, regardless of en, mode or state.
REQ-017 After a load, state SHALL be RUN if load_val != 0, otherwise IDLE.
REQ-018 ld SHALL take priority over decrement and terminal-count handling in the same cycle; tc SHALL be 0 on that edge.
REQ-019 In RUN with en=1, ld=0 and count > 1, count SHALL decrement by 1 per edge.
REQ-020 In RUN with en=1, ld=0 and count == 1, tc SHALL assert for exactly the next cycle.
REQ-021 In the REQ-020 case with mode=0, count SHALL become 0 and state IDLE.
REQ-022 In the REQ-020 case with mode=1, count SHALL become the reload value and state SHALL stay RUN.
REQ-023 With en=0, count, state and reload SHALL hold and tc SHALL be 0.
REQ-024 In IDLE, count SHALL stay at 0 with no underflow wrap, even with en=1.
REQ-025 mode SHALL be sampled only at terminal count; changing it mid-run SHALL have no other effect.
REQ-026 Latency: count SHALL reflect ld or decrement one edge after the input is sampled; zero SHALL follow count combinationally.
REQ-027 load_val = 2^COUNT_BITS-1 SHALL count the full range without overflow.
REQ-028 Auto-reload with reload value 1 SHALL give tc on every enabled cycle.

Reset
REQ-029 rst=1 at an edge SHALL force every channel to count=0, reload=0, state IDLE, tc=0.
REQ-030 rst SHALL take priority over ld and en.
REQ-031 rst asserted mid-count SHALL abort the count with no tc pulse.
REQ-032 Out of reset: zero SHALL be all ones and busy 0.

Structure
REQ-033 The state encodings (IDLE=0, RUN=1) and mode encodings SHALL live in the shared defines file timer_defs.
REQ-034 One channel SHALL be the sub-module down_timer_chan, instantiated NUM_CH times with a generate loop.
REQ-035 The decrement SHALL use the team NBitAddSub adder in subtract mode with b=1.

Verification
REQ-036 rst, then ld[0]=1 with load_val=3, en=1, mode=0 -> count0 reads 3,2,1,0; tc0 high only on the edge where count0 reaches 0; then IDLE, busy 0.
REQ-037 load_val=2, mode=1, en=1 held -> count0 sequence 2,1,2,1,... with tc0 each time count0 reloads to 2.
REQ-038 en toggles 1,0,0,1 from count 5 -> count reads 4,4,4,3; no tc.
REQ-039 count==1 with ld=1, load_val=7 on the same edge -> count=7, tc=0, state RUN.
REQ-040 rst at count=4 -> next edge count=0, tc=0, zero=1; en=1 in IDLE keeps count at 0.
REQ-041 NUM_CH=4, channels loaded with 1,2,3,0 on one edge -> tc pulses on successive cycles for channels 0,1,2; channel 3 never pulses; busy falls after channel 2's tc cycle.
